// File: rtl/uart_rx.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver with a single-byte holding register and a ready/valid
//   consumer handshake. The line is sampled at mid-bit using one bit-period
//   counter. Reception never stalls. A byte that arrives while the previous
//   one is still unconsumed is dropped, and overrun is pulsed.
//
// Parameters
//   CLOCK_FREQ  system clock frequency in Hz
//   BAUD_RATE   line bit rate in bits/s
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   rx         asynchronous serial line, idle high
//   rx_ready   consumer accepts the held byte
//   rx_data    received byte, stable while rx_valid is high
//   rx_valid   rx_data holds an unconsumed byte
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   overrun    one-cycle pulse when a completed byte is dropped
//   busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             rx_meta, line;
  logic             deliver;
  logic             stop_bad;

  // Next-state logic. A frame is always received to completion, whatever the
  // state of the holding register, so the line is never stalled.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    deliver      = 1'b0;
    stop_bad     = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (!line) state_next = START;
      end

      START: begin
        if (cnt == CNT_HALF) begin
          cnt_next = '0;
          if (!line) begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
          end else begin
            // Line is high again at mid start bit: a glitch, not a frame.
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          shift_next = {line, shift[7:1]};  // LSB arrives first
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == CNT_LAST) begin
          // Leave at mid stop bit so a start bit that follows at once is seen.
          cnt_next   = '0;
          state_next = IDLE;
          deliver    = line;
          stop_bad   = !line;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // The synchronizer resets to the idle level so that reset release is
      // not seen as a falling edge.
      rx_meta   <= 1'b1;
      line      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      line      <= rx_meta;
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_idx_next;
      shift     <= shift_next;
      frame_err <= stop_bad;
      overrun   <= 1'b0;

      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx with CLOCK_FREQ=16, BAUD_RATE=1, giving 16 clocks
//   per bit. Frames are driven on the falling clock edge. Outputs are sampled
//   on the falling edge. A monitor counts flag pulses and logs each byte as it
//   is presented.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Monitor state
  int         ferr_cnt  = 0;
  int         ovr_cnt   = 0;
  int         valid_cyc = 0;
  logic       valid_q   = 1'b0;
  logic [7:0] rx_log[$];

  // Snapshots taken before each scenario
  int ferr_base;
  int ovr_base;
  int vcyc_base;
  int log_base;

  uart_rx #(
    .CLOCK_FREQ(16),
    .BAUD_RATE (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
    if (rx_valid)  valid_cyc++;
    if (rx_valid && !valid_q) rx_log.push_back(rx_data);
    valid_q = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full 8N1 frame. The call starts and ends on a falling edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic snapshot();
    ferr_base = ferr_cnt;
    ovr_base  = ovr_cnt;
    vcyc_base = valid_cyc;
    log_base  = rx_log.size();
  endtask

  initial begin
    logic [7:0] b81;
    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check("reset_rx_valid",  32'(rx_valid),  32'd0);
    check("reset_rx_data",   32'(rx_data),   32'h00);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun",   32'(overrun),   32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5 with a good stop bit, consumer not ready
    snapshot();
    send_frame(8'hA5, 1'b1);
    check("a5_data",  32'(rx_data),  32'hA5);
    check("a5_valid", 32'(rx_valid), 32'd1);
    check("a5_ferr",  32'(ferr_cnt - ferr_base), 32'd0);
    check("a5_ovr",   32'(ovr_cnt - ovr_base),   32'd0);
    repeat (20) @(negedge clk);
    check("a5_hold_valid", 32'(rx_valid), 32'd1);
    check("a5_hold_data",  32'(rx_data),  32'hA5);

    // 0x3C while 0xA5 is still held: dropped with one overrun pulse
    snapshot();
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_pulses", 32'(ovr_cnt - ovr_base), 32'd1);
    check("ovr_data",   32'(rx_data),  32'hA5);
    check("ovr_valid",  32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("consume_valid", 32'(rx_valid), 32'd0);
    check("consume_data",  32'(rx_data),  32'hA5);

    // 0x55 with a low stop bit: frame error, nothing delivered
    snapshot();
    send_frame(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    check("ferr_pulses", 32'(ferr_cnt - ferr_base), 32'd1);
    check("ferr_valid",  32'(rx_valid), 32'd0);
    check("ferr_busy",   32'(busy),     32'd0);
    check("ferr_ovr",    32'(ovr_cnt - ovr_base), 32'd0);

    // 4-clock low glitch while idle
    snapshot();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_during", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_after", 32'(busy),     32'd0);
    check("glitch_valid",      32'(rx_valid), 32'd0);
    check("glitch_ferr",       32'(ferr_cnt - ferr_base), 32'd0);
    check("glitch_ovr",        32'(ovr_cnt - ovr_base),   32'd0);

    // Back-to-back 0x01, 0xFF with the consumer always ready
    snapshot();
    rx_ready = 1'b1;
    send_frame(8'h01, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (5) @(negedge clk);
    rx_ready = 1'b0;
    check("b2b_count", 32'(rx_log.size() - log_base), 32'd2);
    if (rx_log.size() >= log_base + 2) begin
      check("b2b_first",  32'(rx_log[log_base]),     32'h01);
      check("b2b_second", 32'(rx_log[log_base + 1]), 32'hFF);
    end
    check("b2b_valid_cycles", 32'(valid_cyc - vcyc_base), 32'd2);
    check("b2b_ovr",          32'(ovr_cnt - ovr_base),    32'd0);

    // Reset during data bit 3 of 0x81, then a clean 0x7E
    snapshot();
    b81 = 8'h81;
    rx  = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b81[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b81[3];
    repeat (CPB / 2) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("abort_busy_after", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    send_frame(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    check("abort_count", 32'(rx_log.size() - log_base), 32'd1);
    if (rx_log.size() >= log_base + 1)
      check("abort_logged", 32'(rx_log[log_base]), 32'h7E);
    check("abort_data", 32'(rx_data),  32'h7E);
    check("abort_ferr", 32'(ferr_cnt - ferr_base), 32'd0);
    check("abort_ovr",  32'(ovr_cnt - ovr_base),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL take parameter CLOCK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL take parameter BAUD_RATE, default 9600, meaning line bit rate in bits/s.
REQ-003 The block SHALL derive local parameter CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer division), default 5208, meaning clocks per bit period; values below 4 are unsupported.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_ready, input, 1 bit: consumer accepts the held byte.
REQ-008 The block SHALL have port rx_data, output, 8 bits: received byte.
REQ-009 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port overrun, output, 1 bit: one-cycle pulse on a dropped byte.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The block SHALL pass rx through a two-flop synchronizer; all references to the line below mean the synchronized value.
REQ-014 The block SHALL use states IDLE, START, DATA and STOP, with one bit-period counter and one 3-bit bit index.
REQ-015 In IDLE, on line==0 the block SHALL enter START with counter=0.
REQ-016 In START, at counter==CLOCKS_PER_BIT/2-1, the block SHALL do the following:
- if line==0: enter DATA with counter=0 and bit index=0;
- else: discard as a glitch, return to IDLE, and raise no flags.
REQ-017 In DATA, at each counter==CLOCKS_PER_BIT-1, the block SHALL sample the line into the shift register LSB-first (shift right, insert at bit 7) and reset the counter.
REQ-018 After the 8th data sample (bit index==7), the block SHALL enter STOP.
REQ-019 In STOP, at counter==CLOCKS_PER_BIT-1, the block SHALL sample the line and return to IDLE in the same cycle.
REQ-020 If the stop sample is 1, the byte SHALL be delivered per REQ-022..024.
REQ-021 If the stop sample is 0, the block SHALL pulse frame_err for one cycle, discard the byte, and leave rx_data/rx_valid unchanged.
REQ-022 On delivery with rx_valid==0, or with rx_valid==1 and rx_ready==1 in the same cycle, the block SHALL load rx_data and drive rx_valid=1 on the next clock edge.
REQ-023 On delivery with rx_valid==1 and rx_ready==0, the block SHALL drop the new byte, keep the old byte, and pulse overrun for one cycle.
REQ-024 The block SHALL clear rx_valid on a cycle with rx_valid==1 and rx_ready==1 and no simultaneous delivery.
REQ-025 rx_data SHALL be stable while rx_valid==1 and SHALL change only on load.
REQ-026 Reception SHALL proceed independently of rx_valid/rx_ready; the block SHALL never stall the line.
REQ-027 Because the block returns to IDLE at mid-stop-bit, it SHALL detect a start bit arriving immediately after the stop bit.
REQ-028 The counter SHALL be $clog2(CLOCKS_PER_BIT) bits wide and SHALL never exceed CLOCKS_PER_BIT-1.

Reset
REQ-029 While rst==1 at a clock edge, the block SHALL set:
- state=IDLE, counter=0, bit index=0, shift register=0;
- both synchronizer flops=1;
- rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no flag pulses; reception SHALL restart at the next falling edge after reset is released.

Verification
(Benches use CLOCK_FREQ=16, BAUD_RATE=1, so CLOCKS_PER_BIT=16.)
REQ-031 Send 0xA5 with a valid stop bit, rx_ready=0 -> rx_data=0xA5, rx_valid=1 and held, frame_err=0, overrun=0.
REQ-032 With 0xA5 held, send 0x3C with rx_ready=0 -> overrun pulses exactly one cycle, rx_data stays 0xA5; then raise rx_ready for one cycle -> rx_valid=0.
REQ-033 Send 0x55 with stop bit=0 -> frame_err pulses one cycle, rx_valid stays 0, busy=0 afterwards.
REQ-034 Drive a 4-clock low glitch while idle -> returns to IDLE, with no rx_valid, frame_err or overrun.
REQ-035 Hold rx_ready=1 and send 0x01 and 0xFF back-to-back with no idle gap -> both bytes delivered in order, each with a one-cycle rx_valid pulse, no overrun.
REQ-036 Assert rst during data bit 3 of 0x81, then send 0x7E -> no flags, only 0x7E delivered.
